// File: rtl/i2s_rx.sv
// I2S receiver: synchronizes sclk/lrclk/sdata into clk and deserializes
// each left/right word pair. Each completed pair is presented as one
// {left, right} word on a valid/ready output.
//
// Output handshake: a pair transfers on any clk edge where m_tvalid and
// m_tready are both high. While m_tvalid is high and m_tready is low,
// m_tdata holds stable. A new pair that arrives during such a stall is
// dropped, and overrun pulses for one cycle.
module i2s_rx #(
  parameter int DW          = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            sclk,
  input  logic            lrclk,
  input  logic            sdata,
  output logic [2*DW-1:0] m_tdata,
  output logic            m_tvalid,
  input  logic            m_tready,
  output logic            overrun
);

  localparam int CW = $clog2(DW + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(DW - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DW);

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] ws_sync;
  logic [SYNC_STAGES-1:0] sd_sync;
  logic                   sclk_hist;
  logic                   sclk_s;
  logic                   ws_s;
  logic                   sd_s;
  logic                   bit_evt;
  logic                   ws_chg;

  logic                   ws_prev;
  logic                   locked;
  logic                   chan;
  logic [CW-1:0]          bit_cnt;
  logic [DW-1:0]          shift_reg;
  logic [DW-1:0]          word_next;
  logic [DW-1:0]          left_hold;
  logic                   left_ok;
  logic                   pair_stb;
  logic [2*DW-1:0]        pair_data;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign ws_s      = ws_sync[SYNC_STAGES-1];
  assign sd_s      = sd_sync[SYNC_STAGES-1];
  assign bit_evt   = sclk_s & ~sclk_hist;
  assign ws_chg    = ws_s != ws_prev;
  assign word_next = {shift_reg[DW-2:0], sd_s};

  // Bring the asynchronous I2S pins into clk and keep sclk history for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      ws_sync   <= '0;
      sd_sync   <= '0;
      sclk_hist <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      ws_sync   <= {ws_sync[SYNC_STAGES-2:0], lrclk};
      sd_sync   <= {sd_sync[SYNC_STAGES-2:0], sdata};
      sclk_hist <= sclk_s;
    end
  end

  // Framing on each sclk rising edge: delay slot, MSB-first shifting, word completion and pairing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ws_prev   <= 1'b1;
      locked    <= 1'b0;
      chan      <= 1'b0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      left_hold <= '0;
      left_ok   <= 1'b0;
      pair_stb  <= 1'b0;
      pair_data <= '0;
    end else begin
      pair_stb <= 1'b0;
      if (bit_evt) begin
        if (ws_chg) begin
          // A word-select change is always the delay slot of the new half.
          ws_prev   <= ws_s;
          locked    <= 1'b1;
          chan      <= ws_s;
          bit_cnt   <= '0;
          shift_reg <= '0;
          // A left half that never reached DW bits cannot be paired.
          if (ws_s && !chan && (bit_cnt != FULL_CNT)) begin
            left_ok <= 1'b0;
          end
        end else if (locked && (bit_cnt != FULL_CNT)) begin
          shift_reg <= word_next;
          bit_cnt   <= bit_cnt + CW'(1);
          if (bit_cnt == LAST_BIT) begin
            if (!chan) begin
              left_hold <= word_next;
              left_ok   <= 1'b1;
            end else begin
              if (left_ok) begin
                pair_stb  <= 1'b1;
                pair_data <= {left_hold, word_next};
              end
              left_ok <= 1'b0;
            end
          end
        end
      end
    end
  end

  // Output register: accept a pair when empty or draining this cycle; otherwise drop it and flag overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_tdata  <= '0;
      m_tvalid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (pair_stb) begin
        if (!m_tvalid || m_tready) begin
          m_tdata  <= pair_data;
          m_tvalid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (m_tvalid && m_tready) begin
        m_tvalid <= 1'b0;
      end
    end
  end

endmodule
